// File: rtl/ld19_uart_pkg.sv
// ld19_uart_pkg
// Shared constants and types for the LD19 UART transmit and receive paths,
// so both ends agree on bit timing and on the frame bytes they exchange.
//   CLKS_PER_BIT_230400 : clk cycles per bit at 230400 baud from 12 MHz
//   tx_state_e          : transmitter FSM states
//   LD19_HEADER/VERLEN  : first two bytes of every LD19 packet
package ld19_uart_pkg;

    localparam int         CLKS_PER_BIT_230400 = 52;
    localparam logic [7:0] LD19_HEADER         = 8'h54;
    localparam logic [7:0] LD19_VERLEN         = 8'h2C;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// Synchronous byte FIFO in front of the UART shifter.
//   clk, rst_n : clock, asynchronous active-low reset (clears pointers/count)
//   push       : write wr_data; ignored while full
//   wr_data    : write data
//   pop        : advance read pointer; ignored while empty
//   rd_data    : head entry, valid whenever empty=0
//   full/empty : occupancy flags
//   count      : number of stored entries (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module uart_tx_fifo
    import ld19_uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW + 1)'(DEPTH));
    assign empty   = (count == '0);
    // A full FIFO refuses the write even if a pop frees a slot this cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx.sv
// uart_tx
// 8N1 UART transmitter (LSB first) fed by a small byte FIFO. Frames are sent
// back-to-back with no idle gap while the FIFO holds data.
//   clk        : system clock (12 MHz)
//   rst_n      : asynchronous active-low reset; truncates any frame, drops queue
//   tx_data    : byte to send
//   tx_valid   : tx_data valid; transfer on tx_valid && tx_ready at posedge clk
//   tx_ready   : FIFO not full
//   tx         : serial line, idle high, registered
//   busy       : frame on the line or bytes queued
//   fifo_count : bytes queued, not counting the one being shifted
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit after
// the data bits (8E1 / 8E2).
module uart_tx
    import ld19_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_230400,
    parameter int FIFO_DEPTH   = 4,
    parameter int STOP_BITS    = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    tx_state_e     state;
    tx_state_e     state_next;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    frame_data;
    logic [7:0]    head;
    logic          tx_next;
    logic          line_active;
    logic          pop;
    logic          full;
    logic          empty;
    logic          baud_last;
    logic          stop_last;

    uart_tx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (tx_valid),
        .wr_data (tx_data),
        .pop     (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (fifo_count)
    );

    assign tx_ready  = !full;
    assign baud_last = (baud_cnt == CW'(CLKS_PER_BIT - 1));
    // In STOP, bit_idx counts stop bits rather than data bits.
    assign stop_last = baud_last && (bit_idx == 3'(STOP_BITS - 1));
    // Pop from IDLE, or on the final stop cycle for a gap-free next frame.
    assign pop       = !empty && ((state == TX_IDLE) || ((state == TX_STOP) && stop_last));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= TX_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            TX_IDLE: begin
                if (!empty) begin
                    state_next = TX_START;
                end
            end
            TX_START: begin
                if (baud_last) begin
                    state_next = TX_DATA;
                end
            end
            TX_DATA: begin
                if (baud_last && (bit_idx == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
                    state_next = TX_PARITY;
`else
                    state_next = TX_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            TX_PARITY: begin
                if (baud_last) begin
                    state_next = TX_STOP;
                end
            end
`endif
            TX_STOP: begin
                if (stop_last) begin
                    state_next = empty ? TX_IDLE : TX_START;
                end
            end
            default: state_next = TX_IDLE;
        endcase
    end

    // Baud counter and bit index restart on every state change so no bit
    // is ever stretched or shortened.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
        end else if ((state_next != state) || (state == TX_IDLE)) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
        end else if (baud_last) begin
            baud_cnt <= '0;
            bit_idx  <= bit_idx + 1'b1;
        end else begin
            baud_cnt <= baud_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (pop) begin
            frame_data <= head;
        end
    end

    always_comb begin
        tx_next = 1'b1;
        case (state)
            TX_START:  tx_next = 1'b0;
            TX_DATA:   tx_next = frame_data[bit_idx];
`ifdef UART_TX_PARITY_EN
            TX_PARITY: tx_next = ^frame_data;
`endif
            default:   tx_next = 1'b1;
        endcase
    end

    // tx trails the FSM by one clock; line_active keeps busy high until the
    // registered stop bit has actually finished on the line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx          <= 1'b1;
            line_active <= 1'b0;
        end else begin
            tx          <= tx_next;
            line_active <= (state != TX_IDLE);
        end
    end

    assign busy = line_active || (state != TX_IDLE) || !empty;

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;
    import ld19_uart_pkg::*;

    localparam int P = CLKS_PER_BIT_230400;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FRAME = (10 + PAR) * P;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx;
    logic       busy;
    logic [2:0] fifo_count;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic line[$];
    logic mon_en = 1'b0;

    uart_tx dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mon_en) line.push_back(tx);
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Line level at cycle 'off' into a frame carrying byte b.
    function automatic logic exp_level(logic [7:0] b, int off);
        int n;
        n = off / P;
        if (n == 0) return 1'b0;
        if (n <= 8) return b[n-1];
        if (PAR == 1 && n == 9) return ^b;
        return 1'b1;
    endfunction

    // Expected line r cycles after the first byte was accepted, when every
    // byte in q is sent gap-free starting 2 cycles after that accept.
    function automatic logic exp_stream(logic [7:0] q[$], int r);
        int off;
        if (r < 2) return 1'b1;
        off = r - 2;
        if (off >= q.size() * FRAME) return 1'b1;
        return exp_level(q[off / FRAME], off % FRAME);
    endfunction

    task automatic test_reset();
        int bad = 0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        rst_n    = 1'b0;
        repeat (3) tick();
        tests++;
        if ({tx, tx_ready, busy, fifo_count} !== {1'b1, 1'b1, 1'b0, 3'd0}) begin
            fails++;
            $display("FAIL reset_held: tx=%b ready=%b busy=%b count=%0d, want 1 1 0 0", tx, tx_ready, busy, fifo_count);
        end
        rst_n = 1'b1;
        repeat (1000) begin
            tick();
            if ({tx, tx_ready, busy, fifo_count} !== {1'b1, 1'b1, 1'b0, 3'd0}) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL reset_idle: %0d bad idle cycles, want 0", bad);
        end
    endtask

    task automatic test_single();
        logic [7:0] q[$];
        logic [9:0] lv = 10'b1010101000;
        logic       eb;
        int         bad_tx = 0, bad_busy = 0, first_bad = -1;
        q.push_back(8'h54);
        tests++;
        if (tx_ready !== 1'b1) begin
            fails++;
            $display("FAIL single_ready: tx_ready=%b want 1", tx_ready);
        end
        tx_valid = 1'b1;
        tx_data  = 8'h54;
        tick();
        tx_valid = 1'b0;
        tx_data  = 8'hC3;
        tests++;
        if ({tx, busy, fifo_count} !== {1'b1, 1'b1, 3'd1}) begin
            fails++;
            $display("FAIL single_accept: tx=%b busy=%b count=%0d, want 1 1 1", tx, busy, fifo_count);
        end
        for (int r = 1; r <= FRAME + 6; r++) begin
            tick();
            if (r == 1) begin
                tests++;
                if (fifo_count !== 3'd0 || tx !== 1'b1) begin
                    fails++;
                    $display("FAIL single_pop: count=%0d tx=%b, want 0 1", fifo_count, tx);
                end
            end
            if (tx !== exp_stream(q, r)) begin
                bad_tx++;
                if (first_bad < 0) first_bad = r;
            end
            eb = (r < 2 + FRAME);
            if (busy !== eb) bad_busy++;
            if (r >= 2 && (r - 2) % P == P / 2 && (r - 2) / P < 10) begin
                tests++;
                if (tx !== lv[(r - 2) / P]) begin
                    fails++;
                    $display("FAIL single_bit%0d: tx=%b want %b", (r - 2) / P, tx, lv[(r - 2) / P]);
                end
            end
        end
        tests++;
        if (bad_tx != 0) begin
            fails++;
            $display("FAIL single_wave: %0d bad cycles (first r=%0d), want 0", bad_tx, first_bad);
        end
        tests++;
        if (bad_busy != 0) begin
            fails++;
            $display("FAIL single_busy: %0d bad cycles, want 0", bad_busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b[$] = '{8'h00, 8'hFF, 8'hA5, 8'h5A, 8'h2C};
        int   idx = 0, r = -1, e0 = -1, bad_tx = 0, bad_busy = 0, first_bad = -1;
        logic acc, eb;
        for (int n = 0; n < 5 * FRAME + 100; n++) begin
            if (idx < 5) begin
                tx_valid = 1'b1;
                tx_data  = b[idx];
            end else begin
                tx_valid = 1'b0;
            end
            acc = tx_valid && tx_ready;
            tick();
            if (acc) begin
                if (idx == 0) e0 = cyc;
                idx++;
            end
            if (e0 >= 0) begin
                r = cyc - e0;
                if (r == 4) begin
                    tests++;
                    if (fifo_count !== 3'd4 || tx_ready !== 1'b0) begin
                        fails++;
                        $display("FAIL b2b_full: count=%0d ready=%b, want 4 0", fifo_count, tx_ready);
                    end
                end
                if (tx !== exp_stream(b, r)) begin
                    bad_tx++;
                    if (first_bad < 0) first_bad = r;
                end
                eb = (r < 2 + 5 * FRAME);
                if (busy !== eb) bad_busy++;
                if (r >= 2 + 5 * FRAME + 4) break;
            end
        end
        tx_valid = 1'b0;
        tests++;
        if (idx != 5 || r != 2 + 5 * FRAME + 4) begin
            fails++;
            $display("FAIL b2b_progress: accepted=%0d r=%0d, want 5 %0d", idx, r, 2 + 5 * FRAME + 4);
        end
        tests++;
        if (bad_tx != 0) begin
            fails++;
            $display("FAIL b2b_wave: %0d bad cycles (first r=%0d), want 0", bad_tx, first_bad);
        end
        tests++;
        if (bad_busy != 0) begin
            fails++;
            $display("FAIL b2b_busy: %0d bad cycles, want 0", bad_busy);
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] b0 = 8'($urandom) & 8'hF7;
        logic [7:0] q[$];
        int bad = 0;
        tx_valid = 1'b1;
        tx_data  = b0;
        tick();
        tx_data = 8'($urandom);
        tick();
        tx_data = 8'($urandom);
        tick();
        tx_valid = 1'b0;
        repeat (4 * P + 10) tick();
        tests++;
        if (fifo_count !== 3'd2 || tx !== 1'b0) begin
            fails++;
            $display("FAIL midrst_pre: count=%0d tx=%b, want 2 0", fifo_count, tx);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if ({tx, tx_ready, busy, fifo_count} !== {1'b1, 1'b1, 1'b0, 3'd0}) begin
            fails++;
            $display("FAIL midrst_async: tx=%b ready=%b busy=%b count=%0d, want 1 1 0 0", tx, tx_ready, busy, fifo_count);
        end
        tick();
        rst_n = 1'b1;
        repeat (2 * FRAME) begin
            tick();
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL midrst_discard: %0d active cycles after reset, want 0", bad);
        end
        q.push_back(8'h01);
        tx_valid = 1'b1;
        tx_data  = 8'h01;
        tick();
        tx_valid = 1'b0;
        bad = 0;
        for (int r = 1; r <= FRAME + 4; r++) begin
            tick();
            if (tx !== exp_stream(q, r)) bad++;
        end
        tests++;
        if (bad != 0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL midrst_frame: %0d bad cycles busy=%b, want 0 0", bad, busy);
        end
    endtask

    task automatic test_random();
        localparam int N = 48;
        logic [7:0] exp_q[$];
        logic [7:0] got[$];
        logic [7:0] v;
        int   base, i, idx = 0, full_tries = 0, bad_rdy = 0, ferr = 0;
        logic acc, eb;
        base   = line.size();
        mon_en = 1'b1;
        for (int n = 0; n < N * FRAME * 3; n++) begin
            tx_valid = (idx < N) && ($urandom_range(0, 3) != 0);
            tx_data  = 8'($urandom);
            acc = tx_valid && tx_ready;
            if (tx_valid && !tx_ready) full_tries++;
            tick();
            if (acc) begin
                exp_q.push_back(tx_data);
                idx++;
            end
            eb = (fifo_count != 3'd4);
            if (tx_ready !== eb || fifo_count > 3'd4) bad_rdy++;
            if (idx == N && busy === 1'b0) break;
        end
        tx_valid = 1'b0;
        tick();
        tick();
        mon_en = 1'b0;
        tests++;
        if (idx != N || busy !== 1'b0) begin
            fails++;
            $display("FAIL rand_progress: accepted=%0d busy=%b, want %0d 0", idx, busy, N);
        end
        tests++;
        if (full_tries == 0) begin
            fails++;
            $display("FAIL rand_full_tries: %0d pushes while full, want >0", full_tries);
        end
        tests++;
        if (bad_rdy != 0) begin
            fails++;
            $display("FAIL rand_ready: %0d cycles ready!=(count!=4), want 0", bad_rdy);
        end
        i = base;
        while (i + (9 + PAR) * P + P / 2 < line.size()) begin
            if (line[i] == 1'b0) begin
                for (int k = 0; k < 8; k++) v[k] = line[i + (k + 1) * P + P / 2];
                if (PAR == 1 && line[i + 9 * P + P / 2] !== ^v) ferr++;
                if (line[i + (9 + PAR) * P + P / 2] !== 1'b1) ferr++;
                got.push_back(v);
                i += (9 + PAR) * P + P / 2;
            end else begin
                i++;
            end
        end
        tests++;
        if (ferr != 0) begin
            fails++;
            $display("FAIL rand_framing: %0d framing errors, want 0", ferr);
        end
        tests++;
        if (got.size() != exp_q.size()) begin
            fails++;
            $display("FAIL rand_count: %0d bytes decoded, want %0d", got.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < got.size(); k++) begin
            tests++;
            if (got[k] !== exp_q[k]) begin
                fails++;
                $display("FAIL rand_byte%0d: got %h want %h", k, got[k], exp_q[k]);
            end
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        logic [7:0] pb[2] = '{8'h07, 8'h03};
        logic       pe[2] = '{1'b1, 1'b0};
        logic [7:0] q[$];
        logic       eb;
        int         bad, bad_busy;
        for (int k = 0; k < 2; k++) begin
            q.delete();
            q.push_back(pb[k]);
            bad = 0;
            bad_busy = 0;
            tx_valid = 1'b1;
            tx_data  = pb[k];
            tick();
            tx_valid = 1'b0;
            for (int r = 1; r <= FRAME + 4; r++) begin
                tick();
                if (tx !== exp_stream(q, r)) bad++;
                eb = (r < 2 + 11 * P);
                if (busy !== eb) bad_busy++;
                if (r == 2 + 9 * P + P / 2) begin
                    tests++;
                    if (tx !== pe[k]) begin
                        fails++;
                        $display("FAIL parity_bit_%h: tx=%b want %b", pb[k], tx, pe[k]);
                    end
                end
            end
            tests++;
            if (bad != 0 || bad_busy != 0) begin
                fails++;
                $display("FAIL parity_frame_%h: %0d bad tx, %0d bad busy cycles, want 0 0", pb[k], bad, bad_busy);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_reset_midframe();
        test_random();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
